// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } scan_state_e;

   localparam int SEG_W = 7;

   // Bit positions of each segment within a digit's pattern.
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

endpackage

// File: rtl/disp_slot_timer.sv
// Loadable down-counter with terminal-count flag; times both BLANK and ON slots.
module disp_slot_timer
   import disp_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = load ? load_val : cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_nxt = cnt_d;
   assign tc      = (cnt_q == '0);

endmodule

// File: rtl/disp_scan_mux.sv
// N-digit 7-segment scan driver with dead-time blanking and per-digit enable.
// Define DISP_BRIGHTNESS_EN to PWM-gate the digit select by the bright input.
//
// state    | meaning
// ST_IDLE  | single cycle after reset, all outputs dark
// ST_BLANK | dead time between digits, no select active
// ST_ON    | digit scan_idx driven from its shadow registers
module disp_scan_mux
   import disp_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int PRESCALE       = 1000,
   parameter int DEAD_CYCLES    = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                        clk_disp,
   input  logic                        rst,
   input  logic [SEG_W*N_DIGITS-1:0]   seg_data,
   input  logic [N_DIGITS-1:0]         dp,
   input  logic [N_DIGITS-1:0]         digit_en,
   input  logic [3:0]                  bright,
   output logic [SEG_W-1:0]            seg_out,
   output logic                        dp_out,
   output logic [N_DIGITS-1:0]         sel_out,
   output logic [$clog2(N_DIGITS)-1:0] scan_idx,
   output logic                        frame_done
);

   localparam int IDX_W   = $clog2(N_DIGITS);
   localparam int CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);

   scan_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              frame_done_q, frame_done_d;
   logic [SEG_W-1:0]  seg_sh_q, seg_sh_d;
   logic              dp_sh_q, dp_sh_d;
   logic              en_sh_q, en_sh_d;
   logic [3:0]        bright_sh_q, bright_sh_d;
   logic [N_DIGITS-1:0] sel_q, sel_d;
   logic [SEG_W-1:0]  seg_q, seg_d;
   logic              dp_q, dp_d;

   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              tmr_tc;
   logic              enter_on;
   logic              pwm_ok;

   disp_slot_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk_disp),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .cnt_nxt  (cnt_nxt),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = ON_LOAD;
      enter_on     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (DEAD_CYCLES == 0) begin
               enter_on = 1'b1;
            end else begin
               state_d  = ST_BLANK;
               tmr_load = 1'b1;
               tmr_val  = DEAD_LOAD;
            end
         end
         ST_BLANK: begin
            if (tmr_tc) enter_on = 1'b1;
         end
         ST_ON: begin
            if (tmr_tc) begin
               idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
               frame_done_d = (idx_q == LAST_IDX);
               if (DEAD_CYCLES == 0) begin
                  enter_on = 1'b1;
               end else begin
                  state_d  = ST_BLANK;
                  tmr_load = 1'b1;
                  tmr_val  = DEAD_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (enter_on) begin
         state_d  = ST_ON;
         tmr_load = 1'b1;
         tmr_val  = ON_LOAD;
      end

      // Shadow capture at slot start keeps a digit stable for its whole slot.
      seg_sh_d    = enter_on ? seg_data[int'(idx_d)*SEG_W +: SEG_W] : seg_sh_q;
      dp_sh_d     = enter_on ? dp[idx_d]       : dp_sh_q;
      en_sh_d     = enter_on ? digit_en[idx_d] : en_sh_q;
      bright_sh_d = enter_on ? bright          : bright_sh_q;

`ifdef DISP_BRIGHTNESS_EN
      pwm_ok = (cnt_nxt[3:0] <= bright_sh_d);
`else
      pwm_ok = 1'b1;
`endif

      // Outputs are computed from next state so they track the state register.
      sel_d = '0;
      seg_d = '0;
      dp_d  = 1'b0;
      if (state_d == ST_ON && en_sh_d) begin
         seg_d = seg_sh_d;
         dp_d  = dp_sh_d;
         if (pwm_ok) sel_d[idx_d] = 1'b1;
      end
   end

`ifndef DISP_BRIGHTNESS_EN
   logic unused_cnt;
   assign unused_cnt = ^cnt_nxt;
`endif

   always_ff @(posedge clk_disp) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
         seg_sh_q     <= '0;
         dp_sh_q      <= 1'b0;
         en_sh_q      <= 1'b0;
         bright_sh_q  <= '0;
         sel_q        <= '0;
         seg_q        <= '0;
         dp_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
         seg_sh_q     <= seg_sh_d;
         dp_sh_q      <= dp_sh_d;
         en_sh_q      <= en_sh_d;
         bright_sh_q  <= bright_sh_d;
         sel_q        <= sel_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign seg_out    = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign dp_out     = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
   assign sel_out    = (SEL_ACTIVE_LOW != 0) ? ~sel_q : sel_q;
   assign scan_idx   = idx_q;
   assign frame_done = frame_done_q;

endmodule
